// File: rtl/core_rot_buf.sv
// core_rot_buf: 8x8 pixel-set rotation buffer between DMA read and DMA write.
// A set of 64 pixels is captured in raster order, then replayed in rotated
// order (0/90/180/270 degrees, CW or CCW) through a registered output stage.
//
// Optional feature macro: CORE_ROT_BUF_PINGPONG_EN
//   undefined (default): one 64-entry bank, O_COUNT is 7 bits.
//   defined            : two 64-entry banks that alternate, so one set fills
//                        while the previous set drains; O_COUNT is 8 bits.
//
// Handshake rules (both sides): a beat transfers on a rising edge where
// valid and ready are both high. Write side: I_WR_VALID/O_WR_READY.
// Read side: O_RD_VALID/I_RD_READY; O_RD_DATA is held while stalled.
module core_rot_buf #(
    parameter int DATA_W = 24,
`ifdef CORE_ROT_BUF_PINGPONG_EN
    localparam int NB    = 2,
    localparam int CNT_W = 8
`else
    localparam int NB    = 1,
    localparam int CNT_W = 7
`endif
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET_N,
    input  logic              I_CLEAR,
    input  logic              I_DIRECTION,
    input  logic [2:0]        I_DEGREES,
    input  logic [DATA_W-1:0] I_WR_DATA,
    input  logic              I_WR_VALID,
    output logic              O_WR_READY,
    output logic [DATA_W-1:0] O_RD_DATA,
    output logic              O_RD_VALID,
    input  logic              I_RD_READY,
    output logic              O_BUSY,
    output logic [CNT_W-1:0]  O_COUNT
);

    localparam int AW = $clog2(NB * 64);
    // Bank pointers only move when there is a second bank to move to.
    localparam logic BANK_STEP = (NB == 2) ? 1'b1 : 1'b0;

    // Per-bank state: FILL accepts writes, DRAIN replays the stored set.
    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

    state_e            state_q [2];
    state_e            state_d [2];
    logic [1:0]        loaded_q, loaded_d;   // all 64 pixels of the bank moved to output stage
    logic [1:0]        eff_q [2];
    logic [1:0]        eff_d [2];
    logic              wr_bank_q, wr_bank_d;     // bank being filled
    logic              ld_bank_q, ld_bank_d;     // bank feeding the output stage
    logic              fire_bank_q, fire_bank_d; // bank whose pixels are being fired
    logic [5:0]        w_q, w_d;                 // write index
    logic [5:0]        k_q, k_d;                 // next output index to load
    logic [5:0]        f_q, f_d;                 // fires within the current set
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] mem [NB*64];

    logic              wr_ready;
    logic              wr_acc;
    logic              fire;
    logic              has_src;
    logic              load;
    logic [1:0]        deg_fold;
    logic [1:0]        eff_in;
    logic [5:0]        src_idx;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

`ifdef CORE_ROT_BUF_PINGPONG_EN
    assign wr_addr = {wr_bank_q, w_q};
    assign rd_addr = {ld_bank_q, src_idx};
`else
    assign wr_addr = w_q;
    assign rd_addr = src_idx;
`endif

    assign wr_ready = (state_q[wr_bank_q] == FILL);
    assign wr_acc   = I_WR_VALID && wr_ready && !I_CLEAR;
    assign fire     = rd_valid_q && I_RD_READY;
    assign has_src  = (state_q[ld_bank_q] == DRAIN) && !loaded_q[ld_bank_q];
    assign load     = has_src && (!rd_valid_q || fire);

    // Fold unsupported degree codes to 0 and convert CCW to the CW equivalent.
    always_comb begin
        deg_fold = I_DEGREES[2] ? 2'd0 : I_DEGREES[1:0];
        eff_in   = I_DIRECTION ? (2'd0 - deg_fold) : deg_fold;
    end

    // Map output index k (row k[5:3], col k[2:0]) to its raster source index.
    always_comb begin
        src_idx = k_q;
        case (eff_q[ld_bank_q])
            2'd0:    src_idx = {k_q[5:3], k_q[2:0]};
            2'd1:    src_idx = {~k_q[2:0], k_q[5:3]};
            2'd2:    src_idx = {~k_q[5:3], ~k_q[2:0]};
            default: src_idx = {k_q[2:0], ~k_q[5:3]};
        endcase
    end

    // Pixel storage; contents survive reset and flush.
    always_ff @(posedge I_HCLK) begin
        if (wr_acc) begin
            mem[wr_addr] <= I_WR_DATA;
        end
    end

    // State register.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= FILL;
                eff_q[b]   <= 2'd0;
            end
            loaded_q    <= 2'b00;
            wr_bank_q   <= 1'b0;
            ld_bank_q   <= 1'b0;
            fire_bank_q <= 1'b0;
            w_q         <= 6'd0;
            k_q         <= 6'd0;
            f_q         <= 6'd0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                eff_q[b]   <= eff_d[b];
            end
            loaded_q    <= loaded_d;
            wr_bank_q   <= wr_bank_d;
            ld_bank_q   <= ld_bank_d;
            fire_bank_q <= fire_bank_d;
            w_q         <= w_d;
            k_q         <= k_d;
            f_q         <= f_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            count_q     <= count_d;
        end
    end

    // Next-state: fill on accepted writes, load/fire the output stage, flush on clear.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            eff_d[b]   = eff_q[b];
        end
        loaded_d    = loaded_q;
        wr_bank_d   = wr_bank_q;
        ld_bank_d   = ld_bank_q;
        fire_bank_d = fire_bank_q;
        w_d         = w_q;
        k_d         = k_q;
        f_d         = f_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        count_d     = count_q + {{(CNT_W-1){1'b0}}, wr_acc} - {{(CNT_W-1){1'b0}}, fire};

        if (wr_acc) begin
            w_d = w_q + 6'd1;
            if (w_q == 6'd63) begin
                state_d[wr_bank_q] = DRAIN;
                eff_d[wr_bank_q]   = eff_in;
                wr_bank_d          = wr_bank_q ^ BANK_STEP;
            end
        end

        if (load) begin
            rd_data_d  = mem[rd_addr];
            rd_valid_d = 1'b1;
            k_d        = k_q + 6'd1;
            if (k_q == 6'd63) begin
                loaded_d[ld_bank_q] = 1'b1;
                ld_bank_d           = ld_bank_q ^ BANK_STEP;
            end
        end else if (fire) begin
            rd_valid_d = 1'b0;
        end

        // The bank is released only when its last pixel leaves the output stage.
        if (fire) begin
            f_d = f_q + 6'd1;
            if (f_q == 6'd63) begin
                state_d[fire_bank_q]  = FILL;
                loaded_d[fire_bank_q] = 1'b0;
                fire_bank_d           = fire_bank_q ^ BANK_STEP;
            end
        end

        if (I_CLEAR) begin
            for (int b = 0; b < 2; b++) begin
                state_d[b] = FILL;
            end
            loaded_d    = 2'b00;
            wr_bank_d   = 1'b0;
            ld_bank_d   = 1'b0;
            fire_bank_d = 1'b0;
            w_d         = 6'd0;
            k_d         = 6'd0;
            f_d         = 6'd0;
            rd_valid_d  = 1'b0;
            count_d     = '0;
        end
    end

    // Outputs.
    always_comb begin
        O_WR_READY = wr_ready;
        O_RD_DATA  = rd_data_q;
        O_RD_VALID = rd_valid_q;
        O_COUNT    = count_q;
        O_BUSY     = (count_q != '0) || (state_q[0] == DRAIN) || (state_q[1] == DRAIN);
    end

endmodule

// File: tb/tb_core_rot_buf.sv
// Testbench for core_rot_buf: directed sets through a rotation model,
// scoreboard queue popped by an output monitor.
module tb_core_rot_buf;

  localparam int DATA_W = 24;
`ifdef CORE_ROT_BUF_PINGPONG_EN
  localparam int CNT_W = 8;
`else
  localparam int CNT_W = 7;
`endif

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              direction;
  logic [2:0]        degrees;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] exp_q[$];
  int checks;
  int errors;
  int mon_fires;
  int first_out;
  int last_out;

  core_rot_buf #(.DATA_W(DATA_W)) dut (
    .I_HCLK      (clk),
    .I_HRESET_N  (rst_n),
    .I_CLEAR     (clear),
    .I_DIRECTION (direction),
    .I_DEGREES   (degrees),
    .I_WR_DATA   (wr_data),
    .I_WR_VALID  (wr_valid),
    .O_WR_READY  (wr_ready),
    .O_RD_DATA   (rd_data),
    .O_RD_VALID  (rd_valid),
    .I_RD_READY  (rd_ready),
    .O_BUSY      (busy),
    .O_COUNT     (count)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected output order: rotate an 8x8 image 90 deg CW 'eff' times,
  // where one step is out(r,c) = in(7-c, r).
  task automatic push_set(input int base, input int deg, input int dir);
    int img[8][8];
    int tmp[8][8];
    int e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = base + r * 8 + c;
    e = (deg >= 4) ? 0 : deg;
    if (dir != 0) e = (4 - e) % 4;
    for (int s = 0; s < e; s++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          tmp[r][c] = img[7 - c][r];
      img = tmp;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back(DATA_W'(img[r][c]));
  endtask

  task automatic drive_writes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(base + i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  // One full set: fill, drain (ready held high or toggling), end-state checks.
  task automatic run_set(input string tag, input int base, input int deg, input int dir,
                         input bit toggle_ready, input int exp_first, input int exp_last);
    int mcnt;
    int cyc;
    bit will_fire;
    mon_fires = 0;
    push_set(base, deg, dir);
    degrees   = 3'(deg);
    direction = dir[0];
    rd_ready  = 1'b1;
    drive_writes(base, 64);
    check({tag, "_ready_low_in_drain"}, 32'(wr_ready), 32'd0);
    check({tag, "_valid_not_yet"}, 32'(rd_valid), 32'd0);
    check({tag, "_count_full"}, 32'(count), 32'd64);
    // Settings changed after the latch edge must not affect this set.
    degrees   = 3'd1;
    direction = ~direction;
    if (toggle_ready) begin
      wr_valid = 1'b1;
      wr_data  = '1;
    end
    @(posedge clk); #1;
    check({tag, "_first_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_count_after_load"}, 32'(count), 32'd64);
    mcnt = 64;
    cyc  = 0;
    while (!wr_ready && cyc < 400) begin
      rd_ready  = toggle_ready ? ~cyc[0] : 1'b1;
      will_fire = rd_valid && rd_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_fire) mcnt--;
      check({tag, "_count_track"}, 32'(count), 32'(mcnt));
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    if (cyc >= 400) check({tag, "_drain_timeout"}, 32'(cyc), 32'd0);
    if (!toggle_ready) check({tag, "_drain_cycles"}, 32'(cyc), 32'd64);
    check({tag, "_fires"}, 32'(mon_fires), 32'd64);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_end"}, 32'(rd_valid), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_count_end"}, 32'(count), 32'd0);
    check({tag, "_first_pixel"}, 32'(first_out), 32'(exp_first));
    check({tag, "_last_pixel"}, 32'(last_out), 32'(exp_last));
  endtask

  // Monitor: pop and compare on every fire; check data holds while stalled.
  initial begin
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && rd_valid)
        check("stall_hold", 32'(rd_data), 32'(prev_data));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("pixel", 32'(rd_data), 32'(exp));
        end
        if (mon_fires == 0) first_out = int'(rd_data);
        last_out = int'(rd_data);
        mon_fires++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  // Stimulus
  initial begin
    checks    = 0;
    errors    = 0;
    mon_fires = 0;
    first_out = -1;
    last_out  = -1;
    rst_n     = 1'b0;
    clear     = 1'b0;
    direction = 1'b0;
    degrees   = 3'd0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    run_set("rot0",     0, 0, 0, 1'b0,  0, 63);
    run_set("rot90",    0, 1, 0, 1'b0, 56,  7);
    run_set("rot180",   0, 2, 0, 1'b0, 63,  0);
    run_set("rot270",   0, 3, 0, 1'b0,  7, 56);
    run_set("ccw90",    0, 1, 1, 1'b0,  7, 56);
    run_set("deg5",     0, 5, 0, 1'b0,  0, 63);
    run_set("backpr",  64, 2, 1, 1'b1, 127, 64);

    // Flush after 20 fires, then a fresh set.
    mon_fires = 0;
    push_set(200, 0, 0);
    degrees   = 3'd0;
    direction = 1'b0;
    drive_writes(200, 64);
    begin
      int guard;
      guard = 0;
      while (mon_fires < 20 && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) check("clear_wait_timeout", 32'(guard), 32'd0);
    end
    check("pre_clear_count", 32'(count), 32'd44);
    clear    = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_valid", 32'(rd_valid), 32'd0);
    check("clear_count", 32'(count), 32'd0);
    check("clear_wr_ready", 32'(wr_ready), 32'd1);
    check("clear_busy", 32'(busy), 32'd0);
    exp_q.delete();
    rd_ready = 1'b1;
    run_set("after_clr", 300, 2, 0, 1'b0, 363, 300);

    // Asynchronous reset in the middle of a fill.
    degrees = 3'd0;
    drive_writes(1000, 30);
    check("partial_count", 32'(count), 32'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_data", 32'(rd_data), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_set("after_rst", 400, 1, 0, 1'b0, 456, 407);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
